// File: rtl/mem_stage_dmem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_types (package)
// Brief    : Shared RV32I load/store encodings, MEM-stage controller states
//            and small alignment/mask helpers.
// Revision : 1.0 - initial release
// ============================================================================
package rv32i_types;

    // Load funct3 encodings
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    // Store funct3 encodings
    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    // Data-memory controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    // Access size lives in funct3[1:0] for both loads and stores:
    // 10 = word, 01 = half, anything else behaves as a byte (always aligned).
    function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] offset);
        logic ok;
        case (funct3[1:0])
            2'b10:   ok = (offset == 2'b00);
            2'b01:   ok = (offset[0] == 1'b0);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Byte enables for a store at the given byte offset; unknown sizes write nothing.
    function automatic logic [3:0] store_mask(input logic [2:0] funct3, input logic [1:0] offset);
        logic [3:0] m;
        case (funct3)
            SB:      m = 4'b0001 << offset;
            SH:      m = 4'b0011 << offset;
            SW:      m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_dmem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_dmem_ctrl_if
// Brief    : Data-memory / dcache request-response bus. The controller is the
//            master; the memory or cache port is the slave.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_stage_dmem_ctrl_if #(
    parameter int XLEN   = 32,
    parameter int MASK_W = 4
);
    logic [XLEN-1:0]   dmem_address;
    logic              dmem_read;
    logic              dmem_write;
    logic [MASK_W-1:0] dmem_wmask;
    logic [XLEN-1:0]   dmem_wdata;
    logic [XLEN-1:0]   dmem_rdata;
    logic              dmem_resp;

    modport master (
        output dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
        input  dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
        output dmem_rdata, dmem_resp
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_dmem_ctrl_load_align.sv
`default_nettype none
// ============================================================================
// Module   : load_align
// Brief    : Selects the addressed byte/half of a read word and sign- or
//            zero-extends it according to the load funct3.
// Revision : 1.0 - initial release
// ============================================================================
module load_align
    import rv32i_types::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic [XLEN-1:0] rdata,
    input  wire logic [1:0]      offset,
    input  wire logic [2:0]      funct3,
    output logic      [XLEN-1:0] data
);

    logic [XLEN-1:0] byte_shift;
    logic [XLEN-1:0] half_shift;

    // Shift the addressed lane down to bit 0, then extend per load type
    always_comb begin
        byte_shift = rdata >> {offset, 3'b000};
        half_shift = rdata >> {offset[1], 4'b0000};
        case (funct3)
            LB:      data = {{(XLEN-8){byte_shift[7]}},   byte_shift[7:0]};
            LH:      data = {{(XLEN-16){half_shift[15]}}, half_shift[15:0]};
            LW:      data = rdata;
            LBU:     data = {{(XLEN-8){1'b0}},            byte_shift[7:0]};
            LHU:     data = {{(XLEN-16){1'b0}},           half_shift[15:0]};
            default: data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_dmem_ctrl
// Brief    : MEM-stage load/store controller. Accepts an access from EX/MEM,
//            checks alignment, issues a held request on the dmem bus, stalls
//            the pipeline until the response, and returns extended load data.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_dmem_ctrl
    import rv32i_types::*;
#(
    parameter int XLEN   = 32,
    parameter int MASK_W = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              in_valid,
    input  wire logic              in_mem_read,
    input  wire logic              in_mem_write,
    input  wire logic [2:0]        in_funct3,
    input  wire logic [XLEN-1:0]   in_mar,
    input  wire logic [XLEN-1:0]   in_wdata,
    mem_stage_dmem_ctrl_if.master  dmem,
    output logic                   stall,
    output logic      [XLEN-1:0]   load_data,
    output logic                   load_valid,
    output logic                   misalign
);

    dmem_state_t       state_q,     state_d;
    logic [XLEN-1:0]   addr_q,      addr_d;
    logic [XLEN-1:0]   wdata_q,     wdata_d;
    logic [MASK_W-1:0] wmask_q,     wmask_d;
    logic              read_q,      read_d;
    logic              write_q,     write_d;
    logic [2:0]        funct3_q,    funct3_d;
    logic [1:0]        offset_q,    offset_d;
    logic              is_load_q,   is_load_d;
    logic [XLEN-1:0]   load_data_q, load_data_d;
    logic              misalign_q,  misalign_d;

    logic              access;
    logic              is_load;
    logic [XLEN-1:0]   aligned_rdata;

    // A read+write combination is illegal upstream; it is handled as a load.
    assign access  = in_valid & (in_mem_read | in_mem_write);
    assign is_load = in_mem_read;

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata  (dmem.dmem_rdata),
        .offset (offset_q),
        .funct3 (funct3_q),
        .data   (aligned_rdata)
    );

    // Next-state, request latching and pipeline handshake outputs
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        read_d      = read_q;
        write_d     = write_q;
        funct3_d    = funct3_q;
        offset_d    = offset_q;
        is_load_d   = is_load_q;
        load_data_d = load_data_q;
        misalign_d  = 1'b0;
        stall       = 1'b0;
        load_valid  = 1'b0;

        case (state_q)
            IDLE: begin
                if (access) begin
                    if (is_aligned(in_funct3, in_mar[1:0])) begin
                        stall     = 1'b1;
                        addr_d    = {in_mar[XLEN-1:2], 2'b00};
                        wdata_d   = is_load ? '0 : in_wdata;
                        wmask_d   = is_load ? '0 : store_mask(in_funct3, in_mar[1:0]);
                        read_d    = is_load;
                        write_d   = ~is_load;
                        funct3_d  = in_funct3;
                        offset_d  = in_mar[1:0];
                        is_load_d = is_load;
                        state_d   = REQ;
                    end else begin
                        // Dropped: flag it and let the pipeline move on
                        misalign_d = 1'b1;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (dmem.dmem_resp) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (is_load_q) begin
                        load_data_d = aligned_rdata;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                // Stall released here; a new access is only looked at in IDLE
                load_valid = is_load_q;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            funct3_q    <= '0;
            offset_q    <= '0;
            is_load_q   <= 1'b0;
            load_data_q <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            read_q      <= read_d;
            write_q     <= write_d;
            funct3_q    <= funct3_d;
            offset_q    <= offset_d;
            is_load_q   <= is_load_d;
            load_data_q <= load_data_d;
            misalign_q  <= misalign_d;
        end
    end

    assign dmem.dmem_address = addr_q;
    assign dmem.dmem_read    = read_q;
    assign dmem.dmem_write   = write_q;
    assign dmem.dmem_wmask   = wmask_q;
    assign dmem.dmem_wdata   = wdata_q;
    assign load_data         = load_data_q;
    assign misalign          = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_dmem_ctrl
// Brief    : Directed self-checking bench for the MEM-stage dmem controller;
//            the bench plays the memory and counts stall cycles per access.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_dmem_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [2:0]  in_funct3;
    logic [31:0] in_mar;
    logic [31:0] in_wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misalign;

    int errors = 0;
    int checks = 0;

    mem_stage_dmem_ctrl_if #(.XLEN(32), .MASK_W(4)) bus ();

    mem_stage_dmem_ctrl #(.XLEN(32), .MASK_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_mem_read  (in_mem_read),
        .in_mem_write (in_mem_write),
        .in_funct3    (in_funct3),
        .in_mar       (in_mar),
        .in_wdata     (in_wdata),
        .dmem         (bus),
        .stall        (stall),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .misalign     (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one access and acts as a memory answering after wait_cyc
    // extra REQ cycles. Returns what the bus showed and the stall count.
    task automatic run_access(
        input  logic        rd, input logic wr, input logic [2:0] f3,
        input  logic [31:0] mar, input logic [31:0] wd, input logic [31:0] rdata,
        input  int          wait_cyc,
        output int          stalls, output logic [31:0] addr, output logic [31:0] mask,
        output logic [31:0] wdat, output logic rd_seen, output logic wr_seen,
        output logic        stable, output logic lv, output logic [31:0] ld
    );
        int   req;
        logic done;
        @(negedge clk);
        in_valid = 1'b1; in_mem_read = rd; in_mem_write = wr;
        in_funct3 = f3; in_mar = mar; in_wdata = wd;
        bus.dmem_rdata = rdata; bus.dmem_resp = 1'b0;
        stalls = 0; req = 0; done = 1'b0; stable = 1'b1;
        rd_seen = 1'b0; wr_seen = 1'b0; lv = 1'b0; ld = '0;
        addr = '0; mask = '0; wdat = '0;
        for (int i = 0; i < 30 && !done; i++) begin
            #1;
            if (stall) stalls++;
            if (bus.dmem_read || bus.dmem_write) begin
                if (req == 0) begin
                    addr = bus.dmem_address;
                    mask = {28'd0, bus.dmem_wmask};
                    wdat = bus.dmem_wdata;
                end else if (addr !== bus.dmem_address || mask[3:0] !== bus.dmem_wmask ||
                             wdat !== bus.dmem_wdata) begin
                    stable = 1'b0;
                end
                rd_seen = rd_seen | bus.dmem_read;
                wr_seen = wr_seen | bus.dmem_write;
                req++;
                if (req == wait_cyc + 1) bus.dmem_resp = 1'b1;
            end else if (!stall && req > 0) begin
                lv = load_valid;
                ld = load_data;
                done = 1'b1;
                in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
            end
            if (!done) begin
                @(negedge clk);
                bus.dmem_resp = 1'b0;
            end
        end
        chk("access_completed", {31'd0, done}, 32'd1);
    endtask

    int          st;
    logic [31:0] a, m, w, ld;
    logic        rs, ws, stb, lv;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
        in_funct3 = '0; in_mar = '0; in_wdata = '0;
        bus.dmem_rdata = '0; bus.dmem_resp = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_read",       {31'd0, bus.dmem_read},  32'd0);
        chk("rst_write",      {31'd0, bus.dmem_write}, 32'd0);
        chk("rst_addr",       bus.dmem_address,        32'd0);
        chk("rst_wmask",      {28'd0, bus.dmem_wmask}, 32'd0);
        chk("rst_stall",      {31'd0, stall},          32'd0);
        chk("rst_load_valid", {31'd0, load_valid},     32'd0);
        chk("rst_load_data",  load_data,               32'd0);
        chk("rst_misalign",   {31'd0, misalign},       32'd0);
        rst = 1'b0;

        // SW, memory answers after 3 wait cycles
        run_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 3,
                   st, a, m, w, rs, ws, stb, lv, ld);
        chk("sw_stall_cycles", st, 32'd5);
        chk("sw_addr",         a,  32'h100);
        chk("sw_wmask",        m,  32'hF);
        chk("sw_wdata",        w,  32'hDEADBEEF);
        chk("sw_no_read",      {31'd0, rs},  32'd0);
        chk("sw_stable",       {31'd0, stb}, 32'd1);
        chk("sw_no_lvalid",    {31'd0, lv},  32'd0);

        // LB from byte 3, zero-wait memory
        run_access(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF_FF00, 0,
                   st, a, m, w, rs, ws, stb, lv, ld);
        chk("lb_stall_cycles", st, 32'd2);
        chk("lb_addr",         a,  32'h200);
        chk("lb_wmask",        m,  32'h0);
        chk("lb_no_write",     {31'd0, ws}, 32'd0);
        chk("lb_load_valid",   {31'd0, lv}, 32'd1);
        chk("lb_load_data",    ld, 32'hFFFF_FF80);
        #1;
        @(negedge clk); #1;
        chk("lb_lvalid_pulse", {31'd0, load_valid}, 32'd0);
        chk("lb_data_held",    load_data, 32'hFFFF_FF80);

        // LHU / LH of the upper half
        run_access(1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 32'h8001_1234, 0,
                   st, a, m, w, rs, ws, stb, lv, ld);
        chk("lhu_load_data", ld, 32'h0000_8001);
        run_access(1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 32'h8001_1234, 1,
                   st, a, m, w, rs, ws, stb, lv, ld);
        chk("lh_load_data",    ld, 32'hFFFF_8001);
        chk("lh_stall_cycles", st, 32'd3);

        // Misaligned LW is dropped
        @(negedge clk);
        in_valid = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0;
        in_funct3 = 3'b010; in_mar = 32'h102;
        #1;
        chk("mis_stall",   {31'd0, stall},         32'd0);
        @(negedge clk);
        in_valid = 1'b0; in_mem_read = 1'b0;
        #1;
        chk("mis_pulse",   {31'd0, misalign},      32'd1);
        chk("mis_no_read", {31'd0, bus.dmem_read}, 32'd0);
        chk("mis_stall2",  {31'd0, stall},         32'd0);
        @(negedge clk); #1;
        chk("mis_pulse_end", {31'd0, misalign},    32'd0);
        chk("mis_no_read2",  {31'd0, bus.dmem_read}, 32'd0);

        // SB to byte 1
        run_access(1'b0, 1'b1, 3'b000, 32'h301, 32'h0000_AB00, 32'h0, 0,
                   st, a, m, w, rs, ws, stb, lv, ld);
        chk("sb_wmask", m, 32'h2);
        chk("sb_addr",  a, 32'h300);
        chk("sb_wdata", w, 32'h0000_AB00);

        // Spurious response while idle
        @(negedge clk);
        bus.dmem_resp = 1'b1;
        @(negedge clk);
        bus.dmem_resp = 1'b0;
        #1;
        chk("spur_stall",  {31'd0, stall},          32'd0);
        chk("spur_read",   {31'd0, bus.dmem_read},  32'd0);
        chk("spur_write",  {31'd0, bus.dmem_write}, 32'd0);
        chk("spur_lvalid", {31'd0, load_valid},     32'd0);

        // Read and write together behave as a load
        run_access(1'b1, 1'b1, 3'b010, 32'h500, 32'h1111_1111, 32'hCAFE_F00D, 0,
                   st, a, m, w, rs, ws, stb, lv, ld);
        chk("rw_read",      {31'd0, rs}, 32'd1);
        chk("rw_no_write",  {31'd0, ws}, 32'd0);
        chk("rw_load_data", ld, 32'hCAFE_F00D);

        // Reset during REQ
        @(negedge clk);
        in_valid = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0;
        in_funct3 = 3'b010; in_mar = 32'h400;
        #1;
        chk("rr_idle_stall", {31'd0, stall}, 32'd1);
        @(negedge clk); #1;
        chk("rr_req_read", {31'd0, bus.dmem_read}, 32'd1);
        rst = 1'b1; in_valid = 1'b0; in_mem_read = 1'b0;
        @(negedge clk); #1;
        chk("rr_read",      {31'd0, bus.dmem_read}, 32'd0);
        chk("rr_addr",      bus.dmem_address,       32'd0);
        chk("rr_stall",     {31'd0, stall},         32'd0);
        chk("rr_load_data", load_data,              32'd0);
        rst = 1'b0;
        run_access(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h1234_5678, 1,
                   st, a, m, w, rs, ws, stb, lv, ld);
        chk("rr_lw_data",   ld, 32'h1234_5678);
        chk("rr_lw_stall",  st, 32'd3);
        chk("rr_lw_addr",   a,  32'h400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
